// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and redirect sequencing for the five-stage pipeline.
// Generates per-latch stall/flush controls, defers commit-time redirects until
// both buses are idle, and keeps stall/redirect performance counters.
// Control outputs are combinational from inputs and state; the stall/flush
// pair on one latch is resolved by the latch itself (a flush beats a stall).
module pipeline_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_busy,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              cm_redirect,
    input  logic [ADDR_W-1:0] cm_redirect_pc,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              flush_wb,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_redirect_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  redirect_count
);

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_BUS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pending_pc;
    logic              pend_load;
    logic              load_use_c;
    logic              bus_idle_c;

    // Load in EX writing a register the ID instruction reads (x0 never hazards)
    assign load_use_c = ex_valid && ex_is_load && (ex_rd != REG_W'(0)) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign bus_idle_c = !if_busy && !mem_busy;

    // State, pending redirect target and performance counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= RUN;
            pending_pc     <= '0;
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            state <= state_nxt;
            if (pend_load) begin
                pending_pc <= cm_redirect_pc;
            end
            if (stall_id) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (pc_redirect) begin
                redirect_count <= redirect_count + CNT_W'(1);
            end
        end
    end

    // Next state and prioritised stall/flush/redirect decode
    always_comb begin
        state_nxt      = state;
        pend_load      = 1'b0;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        flush_mem      = 1'b0;
        flush_wb       = 1'b0;
        pc_redirect    = 1'b0;
        pc_redirect_pc = pending_pc;

        // While reset is held all controls stay quiet and nothing advances
        if (reset) begin
            case (state)
                RUN: begin
                    if (cm_redirect) begin
                        flush_id  = 1'b1;
                        flush_ex  = 1'b1;
                        flush_mem = 1'b1;
                        flush_wb  = 1'b1;
                        if (bus_idle_c) begin
                            pc_redirect    = 1'b1;
                            pc_redirect_pc = cm_redirect_pc;
                        end else begin
                            pend_load = 1'b1;
                            state_nxt = WAIT_BUS;
                            stall_if  = 1'b1;
                            stall_mem = 1'b1;
                        end
                    end else if (mem_busy) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        flush_wb  = 1'b1;
                    end else if (ex_busy) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end else if (load_use_c) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (if_busy) begin
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                WAIT_BUS: begin
                    // Committing stream already flushed; new redirects ignored
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    flush_wb = 1'b1;
                    if (bus_idle_c) begin
                        pc_redirect = 1'b1;
                        state_nxt   = RUN;
                    end else begin
                        // Hold the MEM bus request stable until it completes
                        stall_if  = 1'b1;
                        stall_mem = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

endmodule
